// File: rtl/ram_bus_port_if.sv
// Host-side request/response bus for one ram_bus_port instance.
// The host drives the request fields and holds them stable until ack_o.
interface ram_bus_port_if #(
  parameter int dat_width = 32,
  parameter int adr_width = 32
) ();

  logic                   req_i;
  logic                   we_i;
  logic [adr_width-1:0]   adr_i;
  logic [dat_width/8-1:0] be_i;
  logic [dat_width-1:0]   wdata_i;
  logic                   ack_o;
  logic                   resp_o;
  logic                   err_o;
  logic [dat_width-1:0]   rdata_o;

  modport master (
    output req_i, we_i, adr_i, be_i, wdata_i,
    input  ack_o, resp_o, err_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, adr_i, be_i, wdata_i,
    output ack_o, resp_o, err_o, rdata_o
  );

endinterface

// File: rtl/ram_bus_port.sv
// Host front end for one ram_dual port: byte address -> word index,
// full-word writes go direct, partial byte-enable writes use read-modify-write,
// reads return data with a one-cycle resp strobe. One transaction in flight.
module ram_bus_port #(
  parameter int dat_width = 32,
  parameter int adr_width = 32,
  parameter int mem_size  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_bus_port_if.slave        bus,
  output logic [adr_width-1:0] ram_adr_o,
  output logic                 ram_we_o,
  output logic [dat_width-1:0] ram_dat_o,
  input  logic [dat_width-1:0] ram_dat_i
);

  localparam int BYTES = dat_width / 8;
  localparam int LSB   = (BYTES > 1) ? $clog2(BYTES) : 0;
  // One bit wider than the word index so mem_size itself is representable.
  localparam logic [adr_width:0] MEM_LIMIT = (adr_width + 1)'(mem_size);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAPT  = 3'd2,
    RMW_RD   = 3'd3,
    RMW_MRG  = 3'd4,
    WR       = 3'd5,
    RESP     = 3'd6
  } state_t;

  state_t                 r_state;
  logic                   r_resp;
  logic                   r_err;
  logic [dat_width-1:0]   r_rdata;
  logic [adr_width-1:0]   r_ram_adr;
  logic                   r_ram_we;
  logic [dat_width-1:0]   r_ram_dat;
  logic [dat_width-1:0]   r_wdata;
  logic [BYTES-1:0]       r_be;

  logic [adr_width-1:0]   w_word_idx;
  logic                   w_oor;
  logic                   w_be_full;
  logic                   w_be_none;
  logic                   w_accept;

  // Lane-wise merge: enabled lanes take new write data, others keep RAM data.
  function automatic logic [dat_width-1:0] merge_lanes(
    input logic [dat_width-1:0] new_d,
    input logic [dat_width-1:0] old_d,
    input logic [BYTES-1:0]     be
  );
    logic [dat_width-1:0] merged;
    merged = old_d;
    for (int k = 0; k < BYTES; k++) begin
      if (be[k]) begin
        merged[8*k +: 8] = new_d[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_d[8*k +: 8];
      end
    end
    return merged;
  endfunction

  // Zero-extended word index; range check on the full index so nothing wraps.
  assign w_word_idx = bus.adr_i >> LSB;
  assign w_oor      = ({1'b0, w_word_idx} >= MEM_LIMIT);
  assign w_be_full  = &bus.be_i;
  assign w_be_none  = ~|bus.be_i;

  // Accept only in IDLE and never while reset is asserted.
  assign bus.ack_o  = bus.req_i & (r_state == IDLE) & rst_n;
  assign w_accept   = bus.ack_o;

  assign bus.resp_o  = r_resp;
  assign bus.err_o   = r_err;
  assign bus.rdata_o = r_rdata;
  assign ram_adr_o   = r_ram_adr;
  assign ram_we_o    = r_ram_we;
  assign ram_dat_o   = r_ram_dat;

  // Transaction FSM with registered bus and RAM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_resp    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_ram_adr <= '0;
      r_ram_we  <= 1'b0;
      r_ram_dat <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_oor) begin
              // No RAM access; an out-of-range read reports zero data.
              r_state <= RESP;
              r_resp  <= 1'b1;
              r_err   <= 1'b1;
              if (!bus.we_i) begin
                r_rdata <= '0;
              end
            end else if (bus.we_i && w_be_none) begin
              r_state <= RESP;
              r_resp  <= 1'b1;
              r_err   <= 1'b0;
            end else begin
              r_ram_adr <= w_word_idx;
              r_wdata   <= bus.wdata_i;
              r_be      <= bus.be_i;
              if (!bus.we_i) begin
                r_state <= RD_ISSUE;
              end else if (w_be_full) begin
                r_ram_we  <= 1'b1;
                r_ram_dat <= bus.wdata_i;
                r_state   <= WR;
              end else begin
                r_state <= RMW_RD;
              end
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RD_ISSUE: begin
          r_state <= RD_CAPT;
        end
        RD_CAPT: begin
          r_rdata <= ram_dat_i;
          r_resp  <= 1'b1;
          r_err   <= 1'b0;
          r_state <= RESP;
        end
        RMW_RD: begin
          r_state <= RMW_MRG;
        end
        RMW_MRG: begin
          r_ram_dat <= merge_lanes(r_wdata, ram_dat_i, r_be);
          r_ram_we  <= 1'b1;
          r_state   <= WR;
        end
        WR: begin
          r_ram_we <= 1'b0;
          r_resp   <= 1'b1;
          r_err    <= 1'b0;
          r_state  <= RESP;
        end
        RESP: begin
          r_resp  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_resp   <= 1'b0;
          r_err    <= 1'b0;
          r_ram_we <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_port.sv
// Scoreboard bench for ram_bus_port: a word-array reference model predicts
// each response and RAM write at acceptance; a monitor checks them as they appear.
module tb_ram_bus_port;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MEMN = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] ram_adr;
  logic          ram_we;
  logic [DW-1:0] ram_dat_w;
  logic [DW-1:0] ram_rd = 32'h0;
  logic [DW-1:0] ram_mem [0:MEMN-1] = '{default: 32'h0};

  ram_bus_port_if #(.dat_width(DW), .adr_width(AW)) bus ();

  ram_bus_port #(.dat_width(DW), .adr_width(AW), .mem_size(MEMN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_adr_o (ram_adr),
    .ram_we_o  (ram_we),
    .ram_dat_o (ram_dat_w),
    .ram_dat_i (ram_rd)
  );

  always #5 clk = ~clk;

  // Synchronous RAM stand-in: read-first, data valid the cycle after the address.
  always @(posedge clk) begin
    if (ram_we && ram_adr < MEMN) ram_mem[ram_adr[9:0]] <= ram_dat_w;
    ram_rd <= (ram_adr < MEMN) ? ram_mem[ram_adr[9:0]] : 32'h0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [31:0] rdata; int acc; int lat; } exp_t;
  typedef struct { logic [31:0] adr; logic [31:0] dat; int cyc; } wexp_t;
  exp_t  exp_q[$];
  wexp_t wr_q[$];

  logic [31:0] ref_mem [0:MEMN-1] = '{default: 32'h0};
  logic [31:0] last_rd = 32'h0;
  int total = 0;
  int bad = 0;
  int acc_last = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: outcome of one accepted request from the bus rules.
  task automatic accept(input logic we, input logic [31:0] adr,
                        input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    wexp_t w;
    logic [31:0] word;
    logic [31:0] nw;
    word = adr / 4;
    e.acc = cyc;
    e.err = 1'b0;
    if (word >= MEMN) begin
      e.err = 1'b1;
      e.lat = 1;
      if (!we) last_rd = 32'h0;
    end else if (!we) begin
      e.lat = 3;
      last_rd = ref_mem[word];
    end else if (be == 4'h0) begin
      e.lat = 1;
    end else begin
      e.lat = (be == 4'hF) ? 2 : 4;
      nw = ref_mem[word];
      for (int k = 0; k < 4; k++) if (be[k]) nw[8*k +: 8] = wd[8*k +: 8];
      ref_mem[word] = nw;
      w.adr = word;
      w.dat = nw;
      w.cyc = cyc + e.lat - 1;
      wr_q.push_back(w);
    end
    e.rdata = last_rd;
    exp_q.push_back(e);
    acc_last = cyc;
  endtask

  // Present a request, wait (bounded) for ack; returns one cycle after acceptance with req still high.
  task automatic issue(input logic we, input logic [31:0] adr,
                       input logic [3:0] be, input logic [31:0] wd);
    bit got;
    got = 1'b0;
    bus.req_i = 1'b1;
    bus.we_i = we;
    bus.adr_i = adr;
    bus.be_i = be;
    bus.wdata_i = wd;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk); #1;
      if (bus.ack_o) begin
        accept(we, adr, be, wd);
        got = 1'b1;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout: got no ack expected ack within 60 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.req_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: protocol rules every cycle, pop and compare on each resp and RAM write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ack_o && exp_q.size() != 0) begin
        total++; bad++;
        $display("FAIL ack_busy: got ack=1 expected 0 with transaction outstanding (cycle %0d)", cyc);
      end
      if (bus.err_o && !bus.resp_o) begin
        total++; bad++;
        $display("FAIL err_no_resp: got err=1 expected err=0 while resp=0 (cycle %0d)", cyc);
      end
      if (bus.resp_o) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexp: got resp=1 expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_err", {31'h0, bus.err_o}, {31'h0, e.err});
          chk("resp_rdata", bus.rdata_o, e.rdata);
          chk("resp_latency", cyc - e.acc, e.lat);
        end
      end
      if (ram_we) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL we_unexp: got ram_we=1 expected 0 (cycle %0d)", cyc);
        end else begin
          wexp_t w;
          w = wr_q.pop_front();
          chk("we_adr", ram_adr, w.adr);
          chk("we_dat", ram_dat_w, w.dat);
          chk("we_cycle", cyc, w.cyc);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 32'h0; bus.be_i = 4'hF; bus.wdata_i = 32'h0;
    // Reset held with a pending request: nothing accepted, all outputs zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'h0, bus.ack_o}, 32'h0);
    chk("rst_resp", {31'h0, bus.resp_o}, 32'h0);
    chk("rst_err", {31'h0, bus.err_o}, 32'h0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_ram_adr", ram_adr, 32'h0);
    chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
    chk("rst_ram_dat", ram_dat_w, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rel_ack", {31'h0, bus.ack_o}, 32'h1);
    if (bus.ack_o) accept(1'b0, 32'h0, 4'hF, 32'h0);
    @(posedge clk); #1;
    idle(5);

    // Full write then read-back; partial RMW; out of range; zero byte enables.
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 4'hF, 32'h0);
    issue(1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    issue(1'b0, 32'h1000, 4'hF, 32'h0);
    issue(1'b1, 32'h1000, 4'hF, 32'h55AA55AA);
    issue(1'b0, 32'hFFFF_FFF0, 4'hF, 32'h0);
    issue(1'b1, 32'h10, 4'h0, 32'h12345678);
    issue(1'b0, 32'h13, 4'hF, 32'h0);
    idle(4);

    // Reset pulsed while a partial write to 0x20 sits in the merge cycle.
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = 32'h20; bus.be_i = 4'b0011; bus.wdata_i = 32'hCAFEF00D;
    @(negedge clk); #1;
    chk("abort_ack", {31'h0, bus.ack_o}, 32'h1);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    wr_q.delete();
    last_rd = 32'h0;
    #1;
    chk("abort_we", {31'h0, ram_we}, 32'h0);
    chk("abort_resp", {31'h0, bus.resp_o}, 32'h0);
    @(posedge clk); #1;
    chk("abort_we2", {31'h0, ram_we}, 32'h0);
    rst_n = 1'b1;
    idle(6);
    issue(1'b0, 32'h20, 4'hF, 32'h0);
    // Back-to-back reads with req held: acceptance every read latency + 1 cycles.
    issue(1'b0, 32'h10, 4'hF, 32'h0);
    a = acc_last;
    issue(1'b0, 32'h24, 4'hF, 32'h0);
    chk("b2b_spacing1", acc_last - a, 32'd4);
    a = acc_last;
    issue(1'b0, 32'h20, 4'hF, 32'h0);
    chk("b2b_spacing2", acc_last - a, 32'd4);
    idle(3);

    // Random traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] word;
      logic [3:0] be;
      int sel;
      word = ($urandom_range(0, 15) == 0) ? (MEMN + $urandom_range(0, 63)) : $urandom_range(0, 63);
      sel = $urandom_range(0, 3);
      be = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), word * 4 + $urandom_range(0, 3), be, $urandom);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    // Drain outstanding expectations with a bounded wait.
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    chk("drain_resp", exp_q.size(), 32'd0);
    chk("drain_we", wr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
